// File: rtl/rr_pkg.sv
// Shared constants and state type for the round-robin grant encoder.
package rr_pkg;

    localparam int unsigned N_REQ       = 4;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } rr_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational rotate-and-priority picker: first set request after ptr, wrapping.
module rr_pick
    import rr_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    // Walk from the farthest candidate (ptr itself) to the nearest, so the nearest wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        idx  = '0;
        any  = 1'b0;
        cand = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                idx = cand;
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_grant_encoder.sv
// Four-requester round-robin arbiter with binary grant index and valid strobe.
// Optional grant timeout is compiled in with the RR_TIMEOUT_EN macro.
module rr_grant_encoder
    import rr_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_REQ-1:0] req,
    input  logic             done,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid,
    output logic             busy,
    output logic             timeout
);

    if (TIMEOUT < 2 || TIMEOUT > 255) begin : g_bad_timeout
        $error("rr_grant_encoder: TIMEOUT must be within 2..255");
    end

    rr_state_t        state_q, state_d;
    logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic             owner_req, hit, rel;

    rr_pick u_pick (
        .req (req),
        .ptr (ptr_q),
        .idx (pick_idx),
        .any (pick_any)
    );

    assign owner_req = req[gnt_idx_q];
    assign rel       = done | ~owner_req | hit;

`ifdef RR_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q;

    assign hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (state_q == GRANT) begin
            cnt_d = rel ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            // Only a bare timeout is reported; done or withdrawal take precedence.
            timeout_q <= (state_q == GRANT) & hit & ~done & owner_req;
        end
    end

    assign timeout = timeout_q;
`else
    assign hit     = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        ptr_d       = ptr_q;
        case (state_q)
            IDLE: begin
                gnt_valid_d = pick_any;
                if (pick_any) begin
                    gnt_idx_d = pick_idx;
                    state_d   = GRANT;
                end
            end
            GRANT: begin
                if (rel) begin
                    gnt_valid_d = 1'b0;
                    ptr_d       = gnt_idx_q;
                    state_d     = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
            ptr_q       <= IDX_W'(N_REQ - 1);
        end else begin
            state_q     <= state_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign gnt_idx   = gnt_idx_q;
    assign gnt_valid = gnt_valid_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Self-checking bench for rr_grant_encoder: vector table, corner sequences, random vs model.
module tb_rr_grant_encoder;

    localparam int TO = 4;
`ifdef RR_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] req;
    logic       done;
    logic [1:0] gnt_idx;
    logic       gnt_valid;
    logic       busy;
    logic       timeout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rr_grant_encoder #(.TIMEOUT(TO)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid),
        .busy      (busy),
        .timeout   (timeout)
    );

    // Reference model: owner index, last served requester, cycles held, cool-down flag.
    int m_idx, m_last, m_held;
    bit m_valid, m_busy, m_to, m_rel;

    function automatic void model_reset();
        m_idx = 0; m_last = 3; m_held = 0;
        m_valid = 0; m_busy = 0; m_to = 0; m_rel = 0;
    endfunction

    function automatic void model_update(input logic [3:0] r, input logic d, input logic rn);
        bit w, t, found;
        if (!rn) begin
            model_reset();
        end else if (m_rel) begin
            m_rel = 0; m_busy = 0; m_to = 0;
        end else if (m_valid) begin
            w = !r[m_idx];
            t = TO_EN && (m_held >= TO);
            m_to = 0;
            if (d || w || t) begin
                m_to = t && !d && !w;
                m_valid = 0; m_rel = 1; m_last = m_idx;
            end else begin
                m_held++;
            end
        end else begin
            m_to = 0;
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && r[(m_last + k) % 4]) begin
                    m_idx = (m_last + k) % 4;
                    found = 1;
                end
            end
            if (found) begin
                m_valid = 1; m_busy = 1; m_held = 1;
            end
        end
    endfunction

    task automatic chk(input string name, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic step(input logic [3:0] r, input logic d, input logic rn);
        req = r; done = d; rst_n = rn;
        @(posedge clk);
        model_update(r, d, rn);
        #1;
        chk("model gnt_valid", int'(gnt_valid), int'(m_valid));
        if (m_valid) chk("model gnt_idx", int'(gnt_idx), m_idx);
        chk("model busy", int'(busy), int'(m_busy));
        chk("model timeout", int'(timeout), int'(m_to));
    endtask

    typedef struct {
        logic [3:0] req;
        logic       done;
        logic       rst_n;
        int         idx;
        bit         valid;
        bit         busy;
        bit         to;
    } vec_t;

    vec_t vecs[16];
    int   run;
    int   pulses;

    initial begin
        // req, done, rst_n -> expected idx, valid, busy, timeout after the edge
        vecs[0]  = '{4'b0100, 1'b0, 1'b1, 2, 1, 1, 0};
        vecs[1]  = '{4'b0100, 1'b0, 1'b1, 2, 1, 1, 0};
        vecs[2]  = '{4'b0100, 1'b0, 1'b1, 2, 1, 1, 0};
        vecs[3]  = '{4'b0100, 1'b1, 1'b1, 2, 0, 1, 0};
        vecs[4]  = '{4'b0100, 1'b0, 1'b1, 2, 0, 0, 0};
        vecs[5]  = '{4'b0000, 1'b1, 1'b1, 2, 0, 0, 0};
        vecs[6]  = '{4'b1111, 1'b0, 1'b1, 3, 1, 1, 0};
        vecs[7]  = '{4'b1111, 1'b1, 1'b1, 3, 0, 1, 0};
        vecs[8]  = '{4'b1111, 1'b1, 1'b1, 3, 0, 0, 0};
        vecs[9]  = '{4'b1111, 1'b0, 1'b1, 0, 1, 1, 0};
        vecs[10] = '{4'b1110, 1'b0, 1'b1, 0, 0, 1, 0};
        vecs[11] = '{4'b1110, 1'b1, 1'b1, 0, 0, 0, 0};
        vecs[12] = '{4'b1110, 1'b0, 1'b1, 1, 1, 1, 0};
        vecs[13] = '{4'b1110, 1'b0, 1'b0, 0, 0, 0, 0};
        vecs[14] = '{4'b1111, 1'b0, 1'b1, 0, 1, 1, 0};
        vecs[15] = '{4'b1111, 1'b1, 1'b1, 0, 0, 1, 0};

        model_reset();
        req = '0; done = 1'b0; rst_n = 1'b0;

        // Reset state
        step(4'b0000, 1'b0, 1'b0);
        chk("reset gnt_idx", int'(gnt_idx), 0);
        chk("reset gnt_valid", int'(gnt_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset timeout", int'(timeout), 0);

        // Vector table
        for (int i = 0; i < 16; i++) begin
            step(vecs[i].req, vecs[i].done, vecs[i].rst_n);
            chk($sformatf("vec%0d gnt_valid", i), int'(gnt_valid), int'(vecs[i].valid));
            chk($sformatf("vec%0d gnt_idx", i), int'(gnt_idx), vecs[i].idx);
            chk($sformatf("vec%0d busy", i), int'(busy), int'(vecs[i].busy));
            chk($sformatf("vec%0d timeout", i), int'(timeout), int'(vecs[i].to));
        end

        // Fairness: all requesting, each grant ended by done
        step(4'b0000, 1'b0, 1'b0);
        for (int g = 0; g < 5; g++) begin
            step(4'b1111, 1'b0, 1'b1);
            chk($sformatf("fair grant%0d idx", g), int'(gnt_idx), g % 4);
            chk($sformatf("fair grant%0d valid", g), int'(gnt_valid), 1);
            step(4'b1111, 1'b1, 1'b1);
            step(4'b1111, 1'b0, 1'b1);
        end

        // Withdrawal by owner 1 while 3 waits
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0010, 1'b0, 1'b1);
        chk("wd grant idx", int'(gnt_idx), 1);
        step(4'b1010, 1'b0, 1'b1);
        step(4'b1000, 1'b0, 1'b1);
        chk("wd valid drop", int'(gnt_valid), 0);
        chk("wd no timeout", int'(timeout), 0);
        step(4'b1000, 1'b0, 1'b1);
        chk("wd release busy", int'(busy), 0);
        step(4'b1000, 1'b0, 1'b1);
        chk("wd regrant idx", int'(gnt_idx), 3);
        chk("wd regrant valid", int'(gnt_valid), 1);
        chk("wd regrant timeout", int'(timeout), 0);

        // Timeout: single requester never signals done
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b1);
        run = 1; pulses = 0;
        for (int i = 0; i < 20; i++) begin
            step(4'b0001, 1'b0, 1'b1);
            pulses += int'(timeout);
            if (!gnt_valid) break;
            run++;
        end
`ifdef RR_TIMEOUT_EN
        chk("to high cycles", run, TO);
        chk("to pulse count", pulses, 1);
        step(4'b0001, 1'b0, 1'b1);
        chk("to release pulse cleared", int'(timeout), 0);
        step(4'b0001, 1'b0, 1'b1);
        chk("to regrant idx", int'(gnt_idx), 0);
        chk("to regrant valid", int'(gnt_valid), 1);
`else
        chk("no-to held cycles", run, 21);
        chk("no-to pulse count", pulses, 0);
`endif

        // done + withdrawal on the timeout boundary: one release, no pulse
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0001, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) step(4'b0001, 1'b0, 1'b1);
        chk("sim still granted", int'(gnt_valid), 1);
        step(4'b0000, 1'b1, 1'b1);
        chk("sim valid drop", int'(gnt_valid), 0);
        chk("sim timeout", int'(timeout), 0);
        chk("sim busy release", int'(busy), 1);
        step(4'b0000, 1'b0, 1'b1);
        chk("sim busy clear", int'(busy), 0);
        chk("sim timeout after", int'(timeout), 0);
        step(4'b0000, 1'b0, 1'b1);
        chk("sim no regrant", int'(gnt_valid), 0);

        // Reset mid-grant
        step(4'b0000, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0);
        chk("rst mid idx", int'(gnt_idx), 0);
        chk("rst mid valid", int'(gnt_valid), 0);
        chk("rst mid busy", int'(busy), 0);
        step(4'b1111, 1'b0, 1'b1);
        chk("rst regrant idx", int'(gnt_idx), 0);
        chk("rst regrant valid", int'(gnt_valid), 1);

        // Random stimulus against the model
        for (int i = 0; i < 600; i++) begin
            logic [3:0] r;
            logic       d, rn;
            r  = 4'($urandom);
            if ($urandom_range(0, 3) == 0) r = 4'b0000;
            d  = ($urandom_range(0, 5) == 0);
            rn = ($urandom_range(0, 59) != 0);
            step(r, d, rn);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
